// File: rtl/multiplier_64.sv
// Iterative radix-4 Booth multiplier: WIDTH x WIDTH -> 2*WIDTH signed product, one Booth step per cycle.
// Optional MULTIPLIER_64_UNSIGNED_EN adds an is_unsigned port (operands widened by 2 bits, one extra step).
module multiplier_64 #(
   parameter int WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
`ifdef MULTIPLIER_64_UNSIGNED_EN
   input  logic                 is_unsigned,
`endif
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

`ifdef MULTIPLIER_64_UNSIGNED_EN
   localparam int XW = WIDTH + 2;
`else
   localparam int XW = WIDTH;
`endif
   // Accumulator carries two guard bits so that -2A of the most negative operand cannot wrap.
   localparam int UW    = XW + 2;
   localparam int STEPS = XW / 2;
   localparam int CW    = $clog2(STEPS + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [UW-1:0]       mcand_q, mcand_d;
   logic [UW-1:0]       upper_q, upper_d;
   logic [XW-1:0]       lower_q, lower_d;
   logic                ext_q, ext_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [2*WIDTH-1:0]  prod_q, prod_d;

   logic [XW-1:0]       a_ext, b_ext;
   logic [UW-1:0]       pp, sum;
   logic [UW+XW-1:0]    full;

`ifdef MULTIPLIER_64_UNSIGNED_EN
   always_comb begin
      a_ext = is_unsigned ? {2'b00, a} : {{2{a[WIDTH-1]}}, a};
      b_ext = is_unsigned ? {2'b00, b} : {{2{b[WIDTH-1]}}, b};
   end
`else
   always_comb begin
      a_ext = a;
      b_ext = b;
   end
`endif

   always_comb begin
      pp = '0;
      case ({lower_q[1:0], ext_q})
         3'b001, 3'b010: pp = mcand_q;
         3'b011:         pp = mcand_q << 1;
         3'b100:         pp = -(mcand_q << 1);
         3'b101, 3'b110: pp = -mcand_q;
         default:        pp = '0;
      endcase
      sum  = upper_q + pp;
      full = {upper_q, lower_q};
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      upper_d = upper_q;
      lower_d = lower_q;
      ext_d   = ext_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      prod_d  = prod_q;
      case (state_q)
         IDLE: begin
            // The cycle carrying the done pulse is still part of the completing operation.
            if (start && !done_q) begin
               mcand_d = {{2{a_ext[XW-1]}}, a_ext};
               upper_d = '0;
               lower_d = b_ext;
               ext_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            upper_d = {{2{sum[UW-1]}}, sum[UW-1:2]};
            lower_d = {sum[1:0], lower_q[XW-1:2]};
            ext_d   = lower_q[1];
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CW'(STEPS - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            prod_d  = full[2*WIDTH-1:0];
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         upper_q <= '0;
         lower_q <= '0;
         ext_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         mcand_q <= mcand_d;
         upper_q <= upper_d;
         lower_q <= lower_d;
         ext_q   <= ext_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign prod = prod_q;

endmodule

// File: tb/tb_multiplier_64.sv
// Randomized self-checking bench for multiplier_64 against a plain-arithmetic signed product model.
module tb_multiplier_64;

`ifdef MULTIPLIER_64_UNSIGNED_EN
   localparam int LAT = 34;
`else
   localparam int LAT = 33;
`endif

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [63:0]   a;
   logic [63:0]   b;
   logic          busy;
   logic          done;
   logic [127:0]  prod;
`ifdef MULTIPLIER_64_UNSIGNED_EN
   logic          is_unsigned;
`endif

   int            err_cnt;
   int            chk_cnt;
   logic [127:0]  last_prod;

   multiplier_64 #(.WIDTH(64)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
`ifdef MULTIPLIER_64_UNSIGNED_EN
      .is_unsigned (is_unsigned),
`endif
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .prod        (prod)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] model(input logic [63:0] x, input logic [63:0] y);
      logic signed [127:0] sx, sy;
      sx = {{64{x[63]}}, x};
      sy = {{64{y[63]}}, y};
      return sx * sy;
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   // Called at a negedge; finishes at the negedge following the done cycle.
   task automatic run_op(input logic [63:0] op_a, input logic [63:0] op_b, input bit poke);
      logic [127:0] exp_p;
      int cyc;
      exp_p = model(op_a, op_b);
      start = 1'b1;
      a     = op_a;
      b     = op_b;
      @(negedge clk);
      start = 1'b0;
      a     = rand64();
      b     = rand64();
      cyc   = 1;
      check("busy_after_start", busy, 1'b1);
      check("prod_held_on_start", prod, last_prod);
      while (done !== 1'b1 && cyc < LAT + 20) begin
         start = (poke && (cyc == 5 || cyc == LAT - 1)) ? 1'b1 : 1'b0;
         if (start) begin
            a = rand64();
            b = rand64();
         end
         @(negedge clk);
         cyc++;
      end
      check("latency", cyc, LAT + 1);
      check("prod", prod, exp_p);
      check("busy_at_done", busy, 1'b0);
      start = 1'b1;
      a     = rand64();
      b     = rand64();
      @(negedge clk);
      start = 1'b0;
      check("done_one_cycle", done, 1'b0);
      check("start_in_done_ignored", busy, 1'b0);
      check("prod_hold", prod, exp_p);
      last_prod = exp_p;
      $display("op a=%h b=%h prod=%h latency=%0d", op_a, op_b, prod, cyc);
   endtask

   logic [63:0] corner [6];

   initial begin
      bit seen;
      err_cnt   = 0;
      chk_cnt   = 0;
      last_prod = '0;
      rst_n     = 1'b0;
      start     = 1'b0;
      a         = '0;
      b         = '0;
`ifdef MULTIPLIER_64_UNSIGNED_EN
      is_unsigned = 1'b0;
`endif
      corner[0] = 64'h0;
      corner[1] = 64'h1;
      corner[2] = 64'hFFFF_FFFF_FFFF_FFFF;
      corner[3] = 64'h8000_0000_0000_0000;
      corner[4] = 64'h7FFF_FFFF_FFFF_FFFF;
      corner[5] = 64'h2;

      repeat (3) @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_prod", prod, 128'h0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(64'd0, 64'd0, 1'b0);
      run_op(64'd2, 64'd3, 1'b1);
      run_op(64'd15, 64'd15, 1'b0);
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
      run_op(64'h8000_0000_0000_0000, 64'd2, 1'b1);
      run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      check("spec_min_x2", last_prod, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000 & {128{1'b0}} | model(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000) & 128'h0 | 128'h4000_0000_0000_0000_0000_0000_0000_0000 & {128{1'b1}});

      for (int i = 0; i < 24; i++) begin
         logic [63:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : rand64();
         rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : rand64();
         run_op(ra, rb, i[0]);
      end

      // Abort mid-run: reset must clear outputs immediately and suppress the pending done.
      start = 1'b1;
      a     = rand64();
      b     = rand64();
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_done", done, 1'b0);
      check("abort_prod", prod, 128'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < LAT + 10; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
      end
      check("no_done_after_abort", seen, 1'b0);
      last_prod = '0;
      run_op(64'd15, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
